instr_fetch_unit: RTL and testbench

- Front-end fetch stage of the lab CPU, directly upstream of the decode/execute core.
- Converts the top-level start_i/start_addr launch into a sequential instruction stream read from a synchronous instruction ROM.
- Handles stalls and taken-branch redirects from downstream, and raises done when a halt instruction reaches its output.

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch front-end. Streams instructions from a synchronous ROM and
//            handles stall, branch-redirect and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int             ADDR_W     = 8,
  parameter int             INSTR_W    = 9,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               instr_valid_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_v;

  logic              is_halt;
  logic              take_branch;

  assign is_halt     = instr_valid_o && (instr_o == HALT_INSTR);
  assign take_branch = instr_valid_o && branch_taken_i;

  // While stalled the ROM re-reads the in-flight address so its data survives.
  assign imem_addr_o = (state == FETCH && stall_i) ? req_pc : fetch_pc;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      fetch_pc      <= '0;
      req_pc        <= '0;
      req_v         <= 1'b0;
      pc_o          <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      done_o        <= 1'b0;
    end else if (start_i) begin
      state         <= FETCH;
      fetch_pc      <= start_addr;
      req_v         <= 1'b0;
      instr_valid_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (stall_i) begin
            state <= FETCH;
          end else if (is_halt) begin
            // Halt wins over a simultaneous branch request.
            state         <= HALTED;
            done_o        <= 1'b1;
            instr_valid_o <= 1'b0;
          end else if (take_branch) begin
            fetch_pc      <= branch_target_i;
            req_v         <= 1'b0;
            instr_valid_o <= 1'b0;
          end else begin
            instr_o       <= imem_data_i;
            pc_o          <= req_pc;
            instr_valid_o <= req_v;
            req_pc        <= fetch_pc;
            req_v         <= 1'b1;
            fetch_pc      <= fetch_pc + ADDR_W'(1);
          end
        end
        HALTED: begin
          done_o        <= 1'b1;
          instr_valid_o <= 1'b0;
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit with a ROM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [7:0] start_addr;
  logic [7:0] imem_addr_o;
  logic [8:0] imem_data_i;
  logic       stall_i;
  logic       branch_taken_i;
  logic [7:0] branch_target_i;
  logic [8:0] instr_o;
  logic [7:0] pc_o;
  logic       instr_valid_o;
  logic       done_o;

  logic [8:0] mem [256];
  int compared;
  int mismatched;

  // valid, pc, instr, done packed for compact comparisons
  wire [18:0] obs = {instr_valid_o, pc_o, instr_o, done_o};

  instr_fetch_unit #(
    .ADDR_W(8),
    .INSTR_W(9),
    .HALT_INSTR(9'h1FF)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start_i),
    .start_addr     (start_addr),
    .imem_addr_o    (imem_addr_o),
    .imem_data_i    (imem_data_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .instr_valid_o  (instr_valid_o),
    .done_o         (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data_i <= mem[imem_addr_o];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] addr);
    start_addr = addr;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({obs, imem_addr_o} !== {19'h0, 8'h00}) begin
      mismatched++;
      $display("FAIL reset_async: got %h required %h", {obs, imem_addr_o}, 27'h0);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if (obs !== 19'h0) begin
      mismatched++;
      $display("FAIL idle_no_fetch: got %h required %h", obs, 19'h0);
    end
  endtask

  task automatic test_basic();
    launch(8'h00);
    compared++;
    if (instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_latency: valid got %b required 0", instr_valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      compared++;
      if (obs !== {1'b1, 8'(i), (i == 5) ? 9'h1FF : 9'(i), 1'b0}) begin
        mismatched++;
        $display("FAIL basic_seq%0d: got %h required %h", i, obs,
                 {1'b1, 8'(i), (i == 5) ? 9'h1FF : 9'(i), 1'b0});
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if ({instr_valid_o, done_o} !== 2'b01) begin
        mismatched++;
        $display("FAIL basic_done%0d: got %b required 01", i, {instr_valid_o, done_o});
      end
    end
  endtask

  task automatic test_stall();
    launch(8'h00);
    tick();
    tick();
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (obs !== {1'b1, 8'd2, 9'd2, 1'b0}) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got %h required %h", i, obs, {1'b1, 8'd2, 9'd2, 1'b0});
      end
    end
    stall_i = 1'b0;
    for (int i = 3; i < 5; i++) begin
      tick();
      compared++;
      if (obs !== {1'b1, 8'(i), 9'(i), 1'b0}) begin
        mismatched++;
        $display("FAIL stall_resume%0d: got %h required %h", i, obs, {1'b1, 8'(i), 9'(i), 1'b0});
      end
    end
  endtask

  task automatic test_branch();
    mem[8'h40] = 9'h1FF;
    launch(8'h00);
    tick();
    tick();
    // branch request during a stall must be ignored
    stall_i = 1'b1;
    branch_taken_i = 1'b1;
    branch_target_i = 8'h40;
    tick();
    compared++;
    if (obs !== {1'b1, 8'd1, 9'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL branch_stalled: got %h required %h", obs, {1'b1, 8'd1, 9'd1, 1'b0});
    end
    stall_i = 1'b0;
    tick();
    branch_taken_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (instr_valid_o !== 1'b0) begin
        mismatched++;
        $display("FAIL branch_bubble%0d: valid got %b required 0", i, instr_valid_o);
      end
      tick();
    end
    compared++;
    if (obs !== {1'b1, 8'h40, 9'h1FF, 1'b0}) begin
      mismatched++;
      $display("FAIL branch_target: got %h required %h", obs, {1'b1, 8'h40, 9'h1FF, 1'b0});
    end
    // halt outranks a simultaneous branch
    branch_taken_i = 1'b1;
    branch_target_i = 8'h10;
    tick();
    branch_taken_i = 1'b0;
    compared++;
    if ({instr_valid_o, done_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL branch_halt: got %b required 01", {instr_valid_o, done_o});
    end
    tick();
    tick();
    compared++;
    if ({instr_valid_o, done_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL halted_hold: got %b required 01", {instr_valid_o, done_o});
    end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 9'h0AA;
    mem[8'hFF] = 9'h055;
    mem[8'h00] = 9'h1FF;
    launch(8'hFE);
    tick();
    compared++;
    if (obs !== {1'b1, 8'hFE, 9'h0AA, 1'b0}) begin
      mismatched++;
      $display("FAIL wrap_fe: got %h required %h", obs, {1'b1, 8'hFE, 9'h0AA, 1'b0});
    end
    tick();
    compared++;
    if (obs !== {1'b1, 8'hFF, 9'h055, 1'b0}) begin
      mismatched++;
      $display("FAIL wrap_ff: got %h required %h", obs, {1'b1, 8'hFF, 9'h055, 1'b0});
    end
    tick();
    compared++;
    if (obs !== {1'b1, 8'h00, 9'h1FF, 1'b0}) begin
      mismatched++;
      $display("FAIL wrap_00: got %h required %h", obs, {1'b1, 8'h00, 9'h1FF, 1'b0});
    end
    tick();
    compared++;
    if ({instr_valid_o, done_o} !== 2'b01) begin
      mismatched++;
      $display("FAIL wrap_done: got %b required 01", {instr_valid_o, done_o});
    end
  endtask

  task automatic test_restart_held();
    mem[8'd93] = 9'h123;
    mem[8'd94] = 9'h0F0;
    start_addr = 8'd93;
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({instr_valid_o, done_o} !== 2'b00) begin
        mismatched++;
        $display("FAIL restart_held%0d: got %b required 00", i, {instr_valid_o, done_o});
      end
    end
    start_i = 1'b0;
    tick();
    compared++;
    if (instr_valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_latency: valid got %b required 0", instr_valid_o);
    end
    tick();
    compared++;
    if (obs !== {1'b1, 8'd93, 9'h123, 1'b0}) begin
      mismatched++;
      $display("FAIL restart_first: got %h required %h", obs, {1'b1, 8'd93, 9'h123, 1'b0});
    end
    tick();
    compared++;
    if (obs !== {1'b1, 8'd94, 9'h0F0, 1'b0}) begin
      mismatched++;
      $display("FAIL restart_second: got %h required %h", obs, {1'b1, 8'd94, 9'h0F0, 1'b0});
    end
  endtask

  task automatic test_reset_mid_program();
    #3 rst = 1'b1;
    #1;
    compared++;
    if ({obs, imem_addr_o} !== {19'h0, 8'h00}) begin
      mismatched++;
      $display("FAIL midreset_async: got %h required %h", {obs, imem_addr_o}, 27'h0);
    end
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({obs, imem_addr_o} !== {19'h0, 8'h00}) begin
        mismatched++;
        $display("FAIL midreset_idle%0d: got %h required %h", i, {obs, imem_addr_o}, 27'h0);
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b0;
    start_i = 1'b0;
    start_addr = 8'h00;
    stall_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    for (int i = 0; i < 5; i++) mem[i] = 9'(i);
    mem[5] = 9'h1FF;

    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_wrap();
    test_restart_held();
    test_reset_mid_program();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
